// File: rtl/ksa_pkg.sv
// ============================================================================
// Module   : ksa_pkg
// Brief    : Shared width, generate/propagate type and clog2 for the KSA family
// Revision : 1.0
// ============================================================================
`default_nettype none

package ksa_pkg;

    localparam int KSA_WIDTH = 32;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_prefix_level.sv
// ============================================================================
// Module   : ksa_prefix_level
// Brief    : One Kogge-Stone prefix level; bits below SPAN pass through
// Revision : 1.0
// ============================================================================
`default_nettype none

module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = KSA_WIDTH,
    parameter int SPAN  = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < SPAN) begin : g_pass
            assign o_gp[i] = i_gp[i];
        end else begin : g_comb
            assign o_gp[i].g = i_gp[i].g | (i_gp[i].p & i_gp[i-SPAN].g);
            assign o_gp[i].p = i_gp[i].p & i_gp[i-SPAN].p;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ksa_sub_pipe_32bit.sv
// ============================================================================
// Module   : ksa_sub_pipe_32bit
// Brief    : Two-stage Kogge-Stone subtractor A - B - Bin with valid/ready.
//            Define KSA_SUB_OVF_EN to add the registered signed-overflow Ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ksa_sub_pipe_32bit
    import ksa_pkg::*;
#(
    parameter int WIDTH         = KSA_WIDTH,
    parameter int STAGE1_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             out_valid,
`ifdef KSA_SUB_OVF_EN
    output logic             Ovf,
`endif
    input  logic             out_ready
);

    localparam int c_NUM_LEVELS = clog2(WIDTH);

    gp_t [WIDTH-1:0] w_pre;
    gp_t [WIDTH-1:0] w_chain [0:c_NUM_LEVELS];
    gp_t [WIDTH-1:0] w_fin;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_fin_g;
    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;
    logic             w_adv1;
    logic             w_adv2;

    gp_t [WIDTH-1:0]  r_s1_gp;
    logic [WIDTH-1:0] r_s1_p;
    logic             r_s1_cin;
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef KSA_SUB_OVF_EN
    logic             r_ovf;
`endif

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // Subtraction as A + ~B + ~Bin; the carry-in is folded into bit 0's generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
        assign w_p[i]     = A[i] ^ ~B[i];
        assign w_pre[i].p = w_p[i];
        if (i == 0) begin : g_cin
            assign w_pre[i].g = (A[i] & ~B[i]) | (w_p[i] & ~Bin);
        end else begin : g_plain
            assign w_pre[i].g = A[i] & ~B[i];
        end
    end

    assign w_chain[0] = w_pre;

    for (genvar k = 0; k < c_NUM_LEVELS; k++) begin : g_level
        if (k == STAGE1_LEVELS) begin : g_from_reg
            ksa_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_level (
                .i_gp (r_s1_gp),
                .o_gp (w_chain[k+1])
            );
        end else begin : g_from_chain
            ksa_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_level (
                .i_gp (w_chain[k]),
                .o_gp (w_chain[k+1])
            );
        end
    end

    if (STAGE1_LEVELS >= c_NUM_LEVELS) begin : g_fin_reg
        assign w_fin = r_s1_gp;
    end else begin : g_fin_tree
        assign w_fin = w_chain[c_NUM_LEVELS];
    end

    // Only the group generates matter after the last level
    always_comb begin
        w_unused_p = 1'b0;
        w_fin_g    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fin_g[i] = w_fin[i].g;
            w_unused_p = w_unused_p ^ w_fin[i].p;
        end
    end

    assign w_carry = {w_fin_g[WIDTH-2:0], r_s1_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_gp    <= '0;
            r_s1_p     <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_gp  <= w_chain[STAGE1_LEVELS];
                r_s1_p   <= w_p;
                r_s1_cin <= ~Bin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
`ifdef KSA_SUB_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= r_s1_p ^ w_carry;
                r_bout <= ~w_fin_g[WIDTH-1];
`ifdef KSA_SUB_OVF_EN
                // Carry into MSB differing from carry out is exactly signed overflow
                r_ovf  <= w_fin_g[WIDTH-1] ^ w_fin_g[WIDTH-2];
`endif
            end
        end
    end

    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign out_valid = r_s2_valid;
`ifdef KSA_SUB_OVF_EN
    assign Ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ksa_sub_pipe_32bit.sv
// ============================================================================
// Module   : tb_ksa_sub_pipe_32bit
// Brief    : Self-checking bench for ksa_sub_pipe_32bit (vector table + scoreboard)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ksa_sub_pipe_32bit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [31:0] A         = '0;
    logic [31:0] B         = '0;
    logic        Bin       = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [31:0] Diff;
    logic        Bout;
    logic        out_valid;
`ifdef KSA_SUB_OVF_EN
    logic        Ovf;
`endif

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   bp_mode = 0;

    ksa_sub_pipe_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .out_valid (out_valid),
`ifdef KSA_SUB_OVF_EN
        .Ovf       (Ovf),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got bout=%b diff=%h, expected no output", Bout, Diff);
            end else begin
                e = sb.pop_front();
                if ({Bout, Diff} !== {e.bout, e.diff}) begin
                    n_fail++;
                    $display("FAIL result: got bout=%b diff=%h, expected bout=%b diff=%h",
                             Bout, Diff, e.bout, e.diff);
                end
`ifdef KSA_SUB_OVF_EN
                n_tests++;
                if (Ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL ovf: got %b, expected %b", Ovf, e.ovf);
                end
`endif
                if (e.chk_lat) begin
                    n_tests++;
                    if (cyc - e.cyc != 2) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, expected 2", cyc - e.cyc);
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                input logic [31:0] diff, input logic bout, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.bin = bin; v.diff = diff; v.bout = bout; v.ovf = ovf;
        return v;
    endfunction

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        r = {1'b0, a} - {1'b0, b} - {32'b0, bin};
        return mk(a, b, bin, r[31:0], r[32], (a[31] != b[31]) && (r[31] != a[31]));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.diff = v.diff; e.bout = v.bout; e.ovf = v.ovf;
        e.cyc = cyc; e.chk_lat = (bp_mode == 0);
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1;
    endtask

    task automatic wait_accept(input vec_t v);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 200);
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", w);
        end else begin
            push_exp(v);
        end
    endtask

    task automatic send(input vec_t v);
        drive(v);
        wait_accept(v);
    endtask

    task automatic idle_and_drain();
        int w;
        @(posedge clk);
        #1 in_valid = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        vec_t c0, c1, c2;

        // Reset state
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_diff",      64'(Diff),      64'd0);
        check("reset_bout",      64'(Bout),      64'd0);
        #10 rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed table, no backpressure
        bp_mode = 0;
        vecs.push_back(mk(32'd5,        32'd3,        1'b0, 32'h0000_0002, 1'b0, 1'b0));
        vecs.push_back(mk(32'd0,        32'd1,        1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'd1,        1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1));
        vecs.push_back(mk(32'd0,        32'd0,        1'b0, 32'h0000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(32'd0,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1));
        vecs.push_back(mk(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(32'd10,       32'd5,        1'b1, 32'h0000_0004, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd0,        1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0));
        vecs.push_back(mk(32'd1,        32'h8000_0000, 1'b0, 32'h8000_0001, 1'b1, 1'b1));
        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
        idle_and_drain();

        // Capacity: two accepted, third refused while stalled, then FIFO drain
        c0 = mk(32'd100, 32'd1,  1'b0, 32'd99,         1'b0, 1'b0);
        c1 = mk(32'd7,   32'd9,  1'b0, 32'hFFFF_FFFE,  1'b1, 1'b0);
        c2 = mk(32'd50,  32'd20, 1'b1, 32'd29,         1'b0, 1'b0);
        bp_mode = 2;
        repeat (2) @(posedge clk);
        send(c0);
        send(c1);
        drive(c2);
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid",    64'(out_valid), 64'd1);
            check("hold_result",   64'({Bout, Diff}), 64'({c0.bout, c0.diff}));
        end
        bp_mode = 0;
        wait_accept(c2);
        idle_and_drain();

        // Reset with two results in flight
        bp_mode = 2;
        repeat (2) @(posedge clk);
        send(mk(32'd3, 32'd2, 1'b0, 32'd1, 1'b0, 1'b0));
        send(mk(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("preflush_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_diff",      64'(Diff),      64'd0);
        check("flush_bout",      64'(Bout),      64'd0);
        sb.delete();
        bp_mode = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("in_ready_after_flush", 64'(in_ready), 64'd1);
        send(mk(32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_0FFE, 1'b0, 1'b0));
        idle_and_drain();

        // Random operands with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
            v = model(ra, rb, 1'($urandom_range(0, 1)));
            send(v);
        end
        bp_mode = 0;
        idle_and_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
